// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and destination register codes used by
// the ALU, the control unit and the ALU writeback queue.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 16;  // ALU result width (ALUR)
  localparam int unsigned CPU_DEST_W = 4;   // destination register code width

  // Destination register codes
  localparam logic [CPU_DEST_W-1:0] DEST_AC = 4'd0;
  localparam logic [CPU_DEST_W-1:0] DEST_R  = 4'd1;
  localparam logic [CPU_DEST_W-1:0] DEST_R1 = 4'd2;
  localparam logic [CPU_DEST_W-1:0] DEST_R2 = 4'd3;
  localparam logic [CPU_DEST_W-1:0] DEST_R3 = 4'd4;
  localparam logic [CPU_DEST_W-1:0] DEST_TR = 4'd5;
  localparam logic [CPU_DEST_W-1:0] DEST_PC = 4'd6;

endpackage

// File: rtl/alu_wb_mem.sv
// Writeback queue storage: DEPTH x WIDTH array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module alu_wb_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 21
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_wb_queue.sv
// ALU writeback queue: accepts ALU results (data, Z, destination) under valid/ready,
// buffers up to DEPTH of them in order and drains them to the register-file write
// port. Also holds the architectural Z flag, updated from every accepted result.
// Optional feature macro: WB_BYPASS_EN (empty queue forwards the input to out_* in
// the same cycle; consumed directly when out_ready is also high).
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - input handshake (in_ready = !full)
//   in_data/in_z/in_dest - ALU result, zero flag, destination register code
//   out_valid/out_ready  - writeback handshake
//   out_data/out_dest    - head entry, zero when out_valid=0
//   z_flag               - Z of the most recently accepted result
//   count/full/empty     - occupancy status
module alu_wb_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned DEST_W = CPU_DEST_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_z,
  input  logic [DEST_W-1:0]        in_dest,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [DEST_W-1:0]        out_dest,
  output logic                     z_flag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = DEST_W + 1 + DATA_W;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              z_q;
  logic              push, pop;
  logic              mem_we, mem_re;
  logic [ENT_W-1:0]  head_entry;
  logic [DATA_W-1:0] head_data;
  logic [DEST_W-1:0] head_dest;
  logic              unused_head_z;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = ~full;
  assign count    = count_q;
  assign z_flag   = z_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign {head_dest, unused_head_z, head_data} = head_entry;

`ifdef WB_BYPASS_EN
  logic bypass;
  assign bypass    = empty & in_valid;
  assign out_valid = ~empty | in_valid;
  // A bypassed result taken by the register file never occupies a slot.
  assign mem_we    = push & ~(bypass & out_ready);

  always_comb begin
    out_data = '0;
    out_dest = '0;
    if (!empty) begin
      out_data = head_data;
      out_dest = head_dest;
    end else if (in_valid) begin
      out_data = in_data;
      out_dest = in_dest;
    end
  end
`else
  assign out_valid = ~empty;
  assign mem_we    = push;
  assign out_data  = empty ? '0 : head_data;
  assign out_dest  = empty ? '0 : head_dest;
`endif

  // Only stored entries advance the read pointer.
  assign mem_re = pop & ~empty;

  alu_wb_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata ({in_dest, in_z, in_data}),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      z_q      <= 1'b0;
    end else begin
      if (mem_we) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (mem_re) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push)   z_q      <= in_z;
      if (mem_we && !mem_re) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!mem_we && mem_re) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_queue.sv
module tb_alu_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_z;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_dest;
  logic        z_flag;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_wb_queue #(
    .DATA_W (16),
    .DEST_W (4),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_z      (in_z),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .z_flag    (z_flag),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic z, input logic [3:0] dst,
                       input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_z      = z;
    in_dest   = dst;
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 16'hDEAD, 1'b1, 4'd3, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (z_flag !== 1'b0) $display("FAIL reset_z got %b exp 0", z_flag); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    n_total++; if ({empty, full} !== 2'b10) $display("FAIL reset_empty_full got %b exp 10", {empty, full}); else n_pass++;
  endtask

  task automatic test_single();
    drive(1'b1, 16'h1234, 1'b0, 4'd2, 1'b0);
    cycle();
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 16'h1234) $display("FAIL single_data got %h exp 1234", out_data); else n_pass++;
    n_total++; if (out_dest !== 4'd2) $display("FAIL single_dest got %0d exp 2", out_dest); else n_pass++;
    n_total++; if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count); else n_pass++;
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b1);
    cycle();
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (empty !== 1'b1) $display("FAIL single_drain_empty got %b exp 1", empty); else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [4:0] zs;
    zs = 5'b01000;  // z of result i at bit i-1: only the 4th has Z set
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'(i), zs[i-1], 4'(i), 1'b0);
      if (i == 5) begin
        n_total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got %b exp 0", in_ready); else n_pass++;
      end
      cycle();
    end
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (count !== 3'd4) $display("FAIL fill_count got %0d exp 4", count); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL fill_full got %b exp 1", full); else n_pass++;
    n_total++; if (z_flag !== 1'b1) $display("FAIL fill_z got %b exp 1", z_flag); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b1);
      n_total++;
      if (out_data !== 16'(i) || out_dest !== 4'(i))
        $display("FAIL drain_order_%0d got %h/%0d exp %h/%0d", i, out_data, out_dest, i, i);
      else n_pass++;
      cycle();
    end
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0010 + 16'(i), 1'b0, 4'd1, 1'b0);
      cycle();
    end
    drive(1'b1, 16'h00AA, 1'b1, 4'd7, 1'b1);
    cycle();
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (count !== 3'd3) $display("FAIL fullpp_count got %0d exp 3", count); else n_pass++;
    n_total++; if (z_flag !== 1'b0) $display("FAIL fullpp_z got %b exp 0", z_flag); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b1);
      n_total++;
      if (out_data !== 16'h0010 + 16'(i))
        $display("FAIL fullpp_order_%0d got %h exp %h", i, out_data, 16'h0010 + 16'(i));
      else n_pass++;
      cycle();
    end
    // A misplaced write pointer would leave a stale entry at the head here.
    drive(1'b1, 16'h0055, 1'b0, 4'd3, 1'b0);
    cycle();
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (out_data !== 16'h0055) $display("FAIL fullpp_wrptr got %h exp 0055", out_data); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_head [6];
    exp_head = '{16'h0066, 16'h0000, 16'h0101, 16'h0102, 16'h0103, 16'h0104};
    drive(1'b1, 16'h0066, 1'b0, 4'd4, 1'b0);
    cycle();
    drive(1'b1, 16'h0000, 1'b1, 4'd0, 1'b1);
    cycle();
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (count !== 3'd2) $display("FAIL wrap_count got %0d exp 2", count); else n_pass++;
    n_total++; if (z_flag !== 1'b1) $display("FAIL wrap_z got %b exp 1", z_flag); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 16'h0101 + 16'(k), 1'b0, 4'd1, 1'b1);
      n_total++;
      if (out_data !== exp_head[k]) $display("FAIL wrap_head_%0d got %h exp %h", k, out_data, exp_head[k]);
      else n_pass++;
      cycle();
    end
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b1);
    n_total++; if (count !== 3'd2) $display("FAIL wrap_count_end got %0d exp 2", count); else n_pass++;
    n_total++; if (z_flag !== 1'b0) $display("FAIL wrap_z_end got %b exp 0", z_flag); else n_pass++;
    n_total++; if (out_data !== 16'h0105) $display("FAIL wrap_tail0 got %h exp 0105", out_data); else n_pass++;
    cycle();
    n_total++; if (out_data !== 16'h0106) $display("FAIL wrap_tail1 got %h exp 0106", out_data); else n_pass++;
    cycle();
    // Empty with out_ready high: outputs zero, nothing consumed.
    n_total++;
    if ({out_valid, out_data, out_dest} !== 21'd0)
      $display("FAIL empty_outputs got %b/%h/%0d exp 0/0000/0", out_valid, out_data, out_dest);
    else n_pass++;
    cycle();
    n_total++; if (count !== 3'd0) $display("FAIL empty_pop_ignored got %0d exp 0", count); else n_pass++;
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_bypass();
    drive(1'b1, 16'hBEEF, 1'b1, 4'd5, 1'b1);
`ifdef WB_BYPASS_EN
    n_total++; if (out_valid !== 1'b1) $display("FAIL bypass_valid got %b exp 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 16'hBEEF) $display("FAIL bypass_data got %h exp beef", out_data); else n_pass++;
    n_total++; if (out_dest !== 4'd5) $display("FAIL bypass_dest got %0d exp 5", out_dest); else n_pass++;
    cycle();
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (count !== 3'd0) $display("FAIL bypass_count got %0d exp 0", count); else n_pass++;
    n_total++; if (z_flag !== 1'b1) $display("FAIL bypass_z got %b exp 1", z_flag); else n_pass++;
`else
    n_total++; if (out_valid !== 1'b0) $display("FAIL nobypass_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 16'h0000) $display("FAIL nobypass_data got %h exp 0000", out_data); else n_pass++;
    cycle();
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL nobypass_valid_next got %b exp 1", out_valid); else n_pass++;
    n_total++; if (out_data !== 16'hBEEF) $display("FAIL nobypass_data_next got %h exp beef", out_data); else n_pass++;
    n_total++; if (count !== 3'd1) $display("FAIL nobypass_count got %0d exp 1", count); else n_pass++;
    n_total++; if (z_flag !== 1'b1) $display("FAIL nobypass_z got %b exp 1", z_flag); else n_pass++;
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b1);
    cycle();
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0200 + 16'(i), 1'b0, 4'd2, 1'b0);
      cycle();
    end
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (count !== 3'd3) $display("FAIL mid_count_pre got %0d exp 3", count); else n_pass++;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b1);
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (count !== 3'd0) $display("FAIL mid_count got %0d exp 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b exp 0", out_valid); else n_pass++;
    drive(1'b1, 16'h0777, 1'b0, 4'd6, 1'b0);
    cycle();
    drive(1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
    n_total++; if (out_data !== 16'h0777) $display("FAIL mid_after_push got %h exp 0777", out_data); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_z      = 1'b0;
    in_dest   = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_wrap();
    test_bypass();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
